echo_distance_filter: RTL and testbench

- Downstream consumer of the echo pulse-width counter in the ultrasonic ranging path.
- Captures the final pulse-width count when the echo pulse ends and converts it to centimetres with a sequential restoring divider.
- Averages the last 4 distances, drives a near/far presence flag with hysteresis, and flags out-of-range and missing-echo conditions for the game logic.

---
 rtl/echo_distance_filter.sv | 157 +++++++++++++++
 tb/tb_echo_distance_filter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/echo_distance_filter.sv
// echo_distance_filter: captures echo width, divides to cm, optional 4-sample average (ECHO_AVG_EN), presence and fault flags
module echo_distance_filter #(
  parameter int CNT_W          = 20,
  parameter int DIST_W         = 10,
  parameter int TICKS_PER_CM   = 58,
  parameter int MAX_COUNT      = 23200,
  parameter int NEAR_CM        = 20,
  parameter int FAR_CM         = 30,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              echo,
  input  logic [CNT_W-1:0]  count_in,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              near,
  output logic              out_of_range,
  output logic              no_echo
);
  localparam int BW = $clog2(CNT_W);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DIV_V  = CNT_W'(TICKS_PER_CM);
  localparam logic [CNT_W-1:0]  MAX_V  = CNT_W'(MAX_COUNT);
  localparam logic [DIST_W-1:0] NEAR_V = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] FAR_V  = DIST_W'(FAR_CM);
  localparam logic [TW-1:0]     TO_V   = TW'(TIMEOUT_CYCLES);
  localparam logic [BW-1:0]     LAST_V = BW'(CNT_W - 1);

  typedef enum logic [1:0] {IDLE, HIGH, DIV, UPD} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_q;
  logic [CNT_W-1:0]  hold_q, hold_d, rem_q, rem_d, diff;
  logic [CNT_W:0]    trial;
  logic [BW-1:0]     bit_q, bit_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DIST_W-1:0] dist_q, dist_d, quot, avg;
  logic              valid_q, valid_d, near_q, near_d, oor_q, oor_d, noe_q, noe_d;
  logic              rise, fall, timeout, ge;

  assign rise    = sync_q[1] & ~sync_q[2];
  assign fall    = ~sync_q[1] & sync_q[2];
  assign timeout = timer_q == TO_V;
  assign trial   = {rem_q, hold_q[CNT_W-1]};
  assign ge      = trial >= {1'b0, DIV_V};
  assign diff    = trial[CNT_W-1:0] - DIV_V;
  assign quot    = |hold_q[CNT_W-1:DIST_W] ? '1 : hold_q[DIST_W-1:0];

`ifdef ECHO_AVG_EN
  logic [DIST_W-1:0] win_q [4];
  logic [DIST_W-1:0] win_d [4];
  logic [1:0]        ptr_q;
  logic              primed_q;
  logic [DIST_W+1:0] sum;

  // first sample fills the whole window, later ones overwrite the oldest slot
  always_comb begin
    for (int i = 0; i < 4; i++) win_d[i] = primed_q ? win_q[i] : quot;
    if (primed_q) win_d[ptr_q] = quot;
    sum = {2'b0, win_d[0]} + {2'b0, win_d[1]} + {2'b0, win_d[2]} + {2'b0, win_d[3]};
  end

  assign avg = DIST_W'(sum >> 2);

  // window storage commits only on the update cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q    <= '{default: '0};
      ptr_q    <= '0;
      primed_q <= 1'b0;
    end else if (state_q == UPD) begin
      win_q    <= win_d;
      ptr_q    <= ptr_q + 2'd1;
      primed_q <= 1'b1;
    end
  end
`else
  assign avg = quot;
`endif

  // capture, restoring division (hold_q doubles as dividend and quotient), update, timeout
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    timer_d = fall ? '0 : timeout ? timer_q : timer_q + 1'b1;
    dist_d  = dist_q;
    valid_d = 1'b0;
    near_d  = near_q;
    oor_d   = oor_q;
    noe_d   = noe_q | timeout;
    case (state_q)
      IDLE: state_d = rise ? HIGH : IDLE;
      HIGH: begin
        if (timeout) state_d = IDLE;
        else if (fall) begin
          oor_d   = oor_q | hold_q == '0 | hold_q >= MAX_V;
          state_d = (hold_q == '0 || hold_q >= MAX_V) ? IDLE : DIV;
          rem_d   = '0;
          bit_d   = '0;
        end else hold_d = count_in;
      end
      DIV: begin
        rem_d   = ge ? diff : trial[CNT_W-1:0];
        hold_d  = {hold_q[CNT_W-2:0], ge};
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == LAST_V ? UPD : DIV;
      end
      UPD: begin
        oor_d   = 1'b0;
        noe_d   = 1'b0;
        valid_d = 1'b1;
        dist_d  = avg;
        near_d  = avg < NEAR_V ? 1'b1 : avg > FAR_V ? 1'b0 : near_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers and echo synchronizer (sync_q[1] is echo_s, sync_q[2] its previous value)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      hold_q  <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      timer_q <= '0;
      dist_q  <= '0;
      valid_q <= 1'b0;
      near_q  <= 1'b0;
      oor_q   <= 1'b0;
      noe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], echo};
      hold_q  <= hold_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
      timer_q <= timer_d;
      dist_q  <= dist_d;
      valid_q <= valid_d;
      near_q  <= near_d;
      oor_q   <= oor_d;
      noe_q   <= noe_d;
    end
  end

  assign dist_cm      = dist_q;
  assign dist_valid   = valid_q;
  assign near         = near_q;
  assign out_of_range = oor_q;
  assign no_echo      = noe_q;
endmodule

// File: tb/tb_echo_distance_filter.sv
// tb_echo_distance_filter: directed table of echo captures plus timeout, reset-abort and re-trigger sequences
module tb_echo_distance_filter;
`ifdef ECHO_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  typedef struct {
    int cnt;
    int v;
    int o;
    int ad;
    int an;
    int dd;
    int dn;
  } vec_t;

  logic        clk, reset, echo;
  logic [19:0] count_in;
  logic [9:0]  dist_cm;
  logic        dist_valid, near, out_of_range, no_echo;
  int          n_chk = 0, n_fail = 0;
  int          nstb, first;
  vec_t        tbl [16];

  echo_distance_filter #(.TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .echo(echo), .count_in(count_in),
    .dist_cm(dist_cm), .dist_valid(dist_valid), .near(near),
    .out_of_range(out_of_range), .no_echo(no_echo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // one echo pulse: 6-cycle ramp to cnt, raw fall, then 40 watched cycles
  task automatic pulse(input int cnt, input bit glitch, input int rst_at, output int ns, output int fs);
    ns = 0;
    fs = 0;
    @(posedge clk);
    #1 echo = 1'b1;
    for (int i = 0; i < 6; i++) begin
      count_in = 20'(cnt * (i + 1) / 6);
      @(posedge clk);
      #1;
    end
    echo = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (dist_valid) begin
        ns++;
        if (fs == 0) fs = n;
      end
      if (n == 3) count_in = '0;
      if (glitch && n == 8) echo = 1'b1;
      if (glitch && n == 12) echo = 1'b0;
      if (rst_at != 0 && n == rst_at) reset = 1'b1;
      if (rst_at != 0 && n == rst_at + 2) reset = 1'b0;
    end
  endtask

  task automatic chk_out(input string tag, input int idx, input int ad, input int an, input int dd, input int dn, input int o, input int ne);
    chk({tag, ".dist"}, idx, int'(dist_cm), AVG ? ad : dd);
    chk({tag, ".near"}, idx, int'(near), AVG ? an : dn);
    chk({tag, ".oor"}, idx, int'(out_of_range), o);
    chk({tag, ".no_echo"}, idx, int'(no_echo), ne);
  endtask

  initial begin
    tbl = '{
      '{1160,  1, 0, 20,  0, 20,  0},
      '{580,   1, 0, 17,  1, 10,  1},
      '{580,   1, 0, 15,  1, 10,  1},
      '{580,   1, 0, 12,  1, 10,  1},
      '{2320,  1, 0, 17,  1, 40,  0},
      '{2320,  1, 0, 25,  1, 40,  0},
      '{2320,  1, 0, 32,  0, 40,  0},
      '{2320,  1, 0, 40,  0, 40,  0},
      '{1450,  1, 0, 36,  0, 25,  0},
      '{1100,  1, 0, 30,  0, 18,  1},
      '{1218,  1, 0, 26,  0, 21,  1},
      '{23200, 0, 1, 26,  0, 21,  1},
      '{1160,  1, 0, 21,  0, 20,  1},
      '{0,     0, 1, 21,  0, 20,  1},
      '{23199, 1, 0, 114, 0, 399, 0},
      '{57,    1, 0, 110, 0, 0,   1}
    };
    reset = 1'b1;
    echo = 1'b0;
    count_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset.valid", 0, int'(dist_valid), 0);
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      pulse(tbl[i].cnt, 1'b0, 0, nstb, first);
      chk("tbl.strobes", i, nstb, tbl[i].v);
      chk("tbl.latency", i, first, tbl[i].v != 0 ? 24 : 0);
      chk_out("tbl", i, tbl[i].ad, tbl[i].an, tbl[i].dd, tbl[i].dn, tbl[i].o, 0);
    end

    @(posedge clk);
    #1 echo = 1'b1;
    count_in = 20'd1160;
    repeat (100) @(posedge clk);
    #1 chk("stuck.early_no_echo", 0, int'(no_echo), 0);
    repeat (150) @(posedge clk);
    #1 chk("stuck.no_echo", 0, int'(no_echo), 1);
    echo = 1'b0;
    nstb = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (dist_valid) nstb++;
      if (n == 3) count_in = '0;
    end
    chk("stuck.strobes", 0, nstb, 0);
    chk("stuck.no_echo_sticky", 0, int'(no_echo), 1);
    pulse(1160, 1'b0, 0, nstb, first);
    chk("recover.strobes", 0, nstb, 1);
    chk("recover.latency", 0, first, 24);
    chk_out("recover", 0, 109, 0, 20, 1, 0, 0);

    pulse(580, 1'b0, 12, nstb, first);
    chk("abort.strobes", 0, nstb, 0);
    chk_out("abort", 0, 0, 0, 0, 0, 0, 0);
    pulse(1160, 1'b0, 0, nstb, first);
    chk("after_abort.strobes", 0, nstb, 1);
    chk("after_abort.latency", 0, first, 24);
    chk_out("after_abort", 0, 20, 0, 20, 0, 0, 0);

    pulse(2320, 1'b1, 0, nstb, first);
    chk("retrig.strobes", 0, nstb, 1);
    chk("retrig.latency", 0, first, 24);
    chk_out("retrig", 0, 25, 0, 40, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
